// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console/exit responder.
// Address map, STATUS layout and transmitter states.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
    localparam logic [31:0] MMIO_MASK  = 32'hffff_ffc0;
    localparam logic [31:0] MEM_STATUS = 32'h8000_0018;
    localparam logic [31:0] MEM_PUTC   = 32'h8000_001c;
    localparam logic [31:0] MEM_EXIT   = 32'h8000_002c;

    localparam int ST_FULL  = 8;
    localparam int ST_BUSY  = 9;
    localparam int ST_EXITP = 10;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic in_window(input logic [31:0] a);
        return (a & MMIO_MASK) == MMIO_BASE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push on full and pop on empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_console.sv
// MMIO console: STATUS/PUTC/EXIT registers, PUTC FIFO,
// 8N1 serial transmitter and drain-gated exit request.
module mmio_console
    import mmio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_valid,
    output logic        tx,
    output logic        exit_req,
    output logic [31:0] exit_code,
    output logic        mmio_err
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic          req;
    logic          is_status;
    logic          is_putc;
    logic          is_exit;
    logic          is_other;
    logic          stall;
    logic          ack;
    logic          push;
    logic          exit_wr;
    logic          exit_pending;
    logic [31:0]   status_word;
    logic [31:0]   rdata_n;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    tx_state_e     state;
    tx_state_e     state_n;
    logic [DIV_W-1:0] div;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          pop;
    logic          tx_busy;

    // Gate on dmem_valid so a held request is never served twice.
    assign req = dmem_ready && in_window(dmem_addr) && !dmem_valid;

    always_comb begin
        is_status = 1'b0;
        is_putc   = 1'b0;
        is_exit   = 1'b0;
        is_other  = 1'b0;
        unique case (1'b1)
            (dmem_addr == MEM_STATUS): is_status = 1'b1;
            (dmem_addr == MEM_PUTC):   is_putc   = 1'b1;
            (dmem_addr == MEM_EXIT):   is_exit   = 1'b1;
            default:                   is_other  = 1'b1;
        endcase
    end

    assign stall   = req && is_putc && dmem_wstrb[0] && fifo_full;
    assign ack     = req && !stall;
    assign push    = ack && is_putc && dmem_wstrb[0];
    assign exit_wr = ack && is_exit && (|dmem_wstrb) && !exit_req;
    assign tx_busy = (state != TX_IDLE);

    always_comb begin
        status_word           = '0;
        status_word[7:0]      = 8'(fifo_count);
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_BUSY]  = tx_busy;
        status_word[ST_EXITP] = exit_pending;
    end

    always_comb begin
        rdata_n = '0;
        unique case (1'b1)
            is_status: rdata_n = status_word;
            is_exit:   rdata_n = exit_code;
            default:   rdata_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dmem_valid <= 1'b0;
            dmem_rdata <= '0;
            mmio_err   <= 1'b0;
        end else begin
            dmem_valid <= ack;
            dmem_rdata <= ack ? rdata_n : '0;
            mmio_err   <= ack && is_other;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            exit_code    <= '0;
            exit_pending <= 1'b0;
            exit_req     <= 1'b0;
        end else begin
            if (exit_wr) begin
                exit_code    <= dmem_wdata;
                exit_pending <= 1'b1;
            end
            if (exit_pending && fifo_empty && !tx_busy) begin
                exit_req <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (push),
        .pop    (pop),
        .din    (dmem_wdata[7:0]),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tick = (div == DIV_W'(CLKDIV - 1));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= TX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = TX_START;
                end
            end
            TX_START: if (tick) state_n = TX_DATA;
            TX_DATA: begin
                if (tick && bit_idx == 3'd7) begin
                    state_n = TX_STOP;
                end
            end
            TX_STOP: if (tick) state_n = TX_IDLE;
            default: state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == TX_IDLE || tick) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (pop) begin
                shreg   <= fifo_dout;
                bit_idx <= '0;
            end else if (state == TX_DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: register table, serial
// frame shape, FIFO backpressure, exit timing and reset.
module tb_mmio_console;

    localparam int DEPTH  = 8;
    localparam int CLKDIV = 4;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        tx;
    logic        exit_req;
    logic [31:0] exit_code;
    logic        mmio_err;

    int checks = 0;
    int errors = 0;

    mmio_console #(
        .DEPTH  (DEPTH),
        .CLKDIV (CLKDIV)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_valid (dmem_valid),
        .tx         (tx),
        .exit_req   (exit_req),
        .exit_code  (exit_code),
        .mmio_err   (mmio_err)
    );

    always #5 clk = ~clk;

    // Serial receiver model: samples each bit on its first negedge.
    logic [7:0] rx_q[$];
    int         rst_count = 0;
    int         tx_falls = 0;
    int         mon_snap;
    logic [7:0] mon_b;

    always @(negedge resetb) rst_count++;
    always @(negedge tx) tx_falls++;

    initial begin
        forever begin
            @(negedge clk);
            if (resetb === 1'b1 && tx === 1'b0) begin
                mon_snap = rst_count;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKDIV) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (CLKDIV) @(negedge clk);
                if (rst_count == mon_snap && tx === 1'b1) begin
                    rx_q.push_back(mon_b);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, got, exp);
        end
    endtask

    task automatic access(input  logic [31:0] a,
                          input  logic [3:0]  s,
                          input  logic [31:0] d,
                          input  int          bound,
                          output logic [31:0] rd,
                          output logic        er,
                          output int          lat);
        @(posedge clk);
        #1;
        dmem_ready = 1'b1;
        dmem_addr  = a;
        dmem_wstrb = s;
        dmem_wdata = d;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (dmem_valid) begin
                lat = i;
                rd  = dmem_rdata;
                er  = mmio_err;
                break;
            end
        end
        dmem_ready = 1'b0;
        dmem_wstrb = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [39:0] got_frame;
    logic [39:0] exp_frame;
    logic [7:0]  byte_v;
    logic [7:0]  exp_rx[$];
    int          idx;
    int          last_rise;
    logic        prev_tx;
    int          falls0;
    int          wait_n;

    initial begin
        vecs[0]  = '{32'h8000_0018, 4'h0, 32'h0, 1, 32'h0, 0};
        vecs[1]  = '{32'h8000_001c, 4'h0, 32'h0, 1, 32'h0, 0};
        vecs[2]  = '{32'h8000_002c, 4'h0, 32'h0, 1, 32'h0, 0};
        vecs[3]  = '{32'h8000_0004, 4'h0, 32'h0, 1, 32'h0, 1};
        vecs[4]  = '{32'h8000_003c, 4'h0, 32'h0, 1, 32'h0, 1};
        vecs[5]  = '{32'h8000_0000, 4'hf, 32'h5a, 1, 32'h0, 1};
        vecs[6]  = '{32'h8000_0018, 4'hf, 32'h7ff, 1, 32'h0, 0};
        vecs[7]  = '{32'h8000_001c, 4'h2, 32'h77, 1, 32'h0, 0};
        vecs[8]  = '{32'h0000_1000, 4'h0, 32'h0, 0, 32'h0, 0};
        vecs[9]  = '{32'h8000_0040, 4'h0, 32'h0, 0, 32'h0, 0};
        vecs[10] = '{32'h7fff_fffc, 4'hf, 32'h1, 0, 32'h0, 0};
        vecs[11] = '{32'h8000_0018, 4'h0, 32'h0, 1, 32'h0, 0};

        // Reset state
        #1;
        chk("rst_valid", 32'(dmem_valid), 32'h0);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_exit_req", 32'(exit_req), 32'h0);
        chk("rst_exit_code", exit_code, 32'h0);
        chk("rst_mmio_err", 32'(mmio_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resetb = 1'b1;

        // Register table
        for (int v = 0; v < 12; v++) begin
            access(vecs[v].addr, vecs[v].wstrb, vecs[v].wdata,
                   4, rd, er, lat);
            chk($sformatf("vec%0d_valid", v),
                32'(lat != -1), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd1);
                chk($sformatf("vec%0d_rdata", v),
                    rd, vecs[v].exp_rdata);
                chk($sformatf("vec%0d_err", v),
                    32'(er), 32'(vecs[v].exp_err));
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d_onecyc", v),
                    32'({dmem_valid, mmio_err}), 32'h0);
            end
        end
        chk("no_frames_yet", 32'(rx_q.size()), 32'd0);

        // Single frame, 0x41
        access(32'h8000_001c, 4'h1, 32'h41, 4, rd, er, lat);
        chk("putc41_lat", 32'(lat), 32'd1);
        byte_v = 8'h41;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            got_frame[c] = tx;
            if (c < 4) exp_frame[c] = 1'b0;
            else if (c >= 36) exp_frame[c] = 1'b1;
            else exp_frame[c] = byte_v[(c - 4) / 4];
        end
        chk("frame41_lo", got_frame[31:0], exp_frame[31:0]);
        chk("frame41_hi", 32'(got_frame[39:32]),
            32'(exp_frame[39:32]));
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("status_after_41", rd, 32'h0);
        exp_rx.push_back(8'h41);

        // Fill FIFO, then one more write must be held off
        for (int k = 0; k < 9; k++) begin
            access(32'h8000_001c, 4'h1, 32'h30 + k, 4,
                   rd, er, lat);
            chk($sformatf("fill%0d_lat", k), 32'(lat), 32'd1);
            exp_rx.push_back(8'h30 + 8'(k));
        end
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("status_full", rd, 32'h308);
        access(32'h8000_001c, 4'h1, 32'h39, 200, rd, er, lat);
        exp_rx.push_back(8'h39);
        chk("stall_acked", 32'(lat != -1), 32'h1);
        chk("stall_delayed", 32'(lat > 5), 32'h1);
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("status_cnt_le8", 32'(rd[7:0] <= 8'd8), 32'h1);

        wait_n = 0;
        while (rx_q.size() < 11 && wait_n < 800) begin
            @(posedge clk);
            wait_n++;
        end
        chk("rx_count", 32'(rx_q.size()), 32'd11);
        for (int k = 0; k < 11; k++) begin
            if (k < rx_q.size()) begin
                chk($sformatf("rx%0d", k),
                    32'(rx_q[k]), 32'(exp_rx[k]));
            end
        end
        repeat (8) @(posedge clk);
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("status_drained", rd, 32'h0);

        // Exit waits for 'h','i' to drain
        access(32'h8000_001c, 4'h1, 32'h68, 4, rd, er, lat);
        access(32'h8000_001c, 4'h1, 32'h69, 4, rd, er, lat);
        access(32'h8000_002c, 4'hf, 32'h11, 4, rd, er, lat);
        chk("exit1_code", exit_code, 32'h11);
        access(32'h8000_002c, 4'h1, 32'h2a, 4, rd, er, lat);
        chk("exit2_code", exit_code, 32'h2a);
        chk("exit_req_early", 32'(exit_req), 32'h0);
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("status_pending", rd, 32'h601);

        idx = 0;
        last_rise = -100;
        prev_tx = tx;
        while (!exit_req && idx < 300) begin
            @(posedge clk);
            #1;
            idx++;
            if (!prev_tx && tx) last_rise = idx;
            prev_tx = tx;
        end
        chk("exit_req_rose", 32'(exit_req), 32'h1);
        chk("exit_req_timing", 32'(idx - last_rise),
            32'(CLKDIV + 1));
        chk("rx_h", 32'(rx_q.size() > 11 ? rx_q[11] : 8'h0),
            32'h68);
        chk("rx_i", 32'(rx_q.size() > 12 ? rx_q[12] : 8'h0),
            32'h69);
        access(32'h8000_002c, 4'hf, 32'h55, 4, rd, er, lat);
        chk("exit_late_ack", 32'(lat), 32'd1);
        chk("exit_code_frozen", exit_code, 32'h2a);
        access(32'h8000_002c, 4'h0, 32'h0, 4, rd, er, lat);
        chk("exit_read", rd, 32'h2a);
        repeat (4) @(posedge clk);
        chk("exit_req_sticky", 32'(exit_req), 32'h1);

        // Reset mid-DATA with three bytes still queued
        access(32'h8000_001c, 4'h1, 32'h00, 4, rd, er, lat);
        access(32'h8000_001c, 4'h1, 32'h11, 4, rd, er, lat);
        access(32'h8000_001c, 4'h1, 32'h22, 4, rd, er, lat);
        access(32'h8000_001c, 4'h1, 32'h33, 4, rd, er, lat);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_tx_low", 32'(tx), 32'h0);
        resetb = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'h1);
        chk("mid_rst_exit_req", 32'(exit_req), 32'h0);
        chk("mid_rst_exit_code", exit_code, 32'h0);
        falls0 = tx_falls;
        repeat (3) @(posedge clk);
        #1;
        resetb = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_no_output", 32'(tx_falls - falls0),
            32'h0);
        chk("post_rst_tx", 32'(tx), 32'h1);
        access(32'h8000_0018, 4'h0, 32'h0, 4, rd, er, lat);
        chk("post_rst_status", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
